// File: rtl/led_breathe_pkg.sv
// Shared types and defaults for the LED driver blocks (led_breathe, led_cnt).
package led_pkg;

  localparam int DIV_W = 5;
  localparam int PWM_W_DEFAULT = 8;
  localparam logic [DIV_W-1:0] DIV_RST_DEFAULT = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    FALL
  } breathe_state_t;

  // Prescaler terminal count: 2^div - 1.
  function automatic logic [31:0] term_count(input logic [DIV_W-1:0] div);
    return (32'd1 << div) - 32'd1;
  endfunction

endpackage

// File: rtl/led_breathe_if.sv
// Control/status bundle between the register block and the breathing LED driver.
interface led_breathe_if
  import led_pkg::*;
#(
  parameter int PWM_W = PWM_W_DEFAULT
);

  logic [DIV_W-1:0] div_i;
  logic             wren_i;
  logic             en_i;
  logic             led_o;
  logic [PWM_W-1:0] duty_o;
  logic             phase_o;

  modport master (
    output div_i, wren_i, en_i,
    input  led_o, duty_o, phase_o
  );

  modport slave (
    input  div_i, wren_i, en_i,
    output led_o, duty_o, phase_o
  );

endinterface

// File: rtl/led_prescaler.sv
// Power-of-two prescaler: one tick every 2^div cycles, restartable via clr.
module led_prescaler
  import led_pkg::*;
(
  input  logic             clk100,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [31:0] pre_cnt_reg;
  logic        term;

  assign term = (pre_cnt_reg == term_count(div));
  // A tick coinciding with a restart is swallowed so the new period starts clean.
  assign tick = term & ~clr;

  always_ff @(posedge clk100) begin
    if (rst || clr || term) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_reg + 32'd1;
    end
  end

endmodule

// File: rtl/led_breathe.sv
// Breathing PWM LED driver: duty ramps up and down one step per PWM period at most.
module led_breathe
  import led_pkg::*;
#(
  parameter int               PWM_W   = PWM_W_DEFAULT,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_RST_DEFAULT
) (
  input  logic          clk100,
  input  logic          rst,
  led_breathe_if.slave  bus
);

  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  breathe_state_t   state_reg, state_next;
  logic [DIV_W-1:0] div_reg;
  logic [PWM_W-1:0] pwm_cnt_reg, pwm_cnt_next;
  logic [PWM_W-1:0] duty_reg, duty_next;
  logic             step_pend_reg, step_pend_next;
  logic             led_reg, led_next;
  logic             pre_clr;
  logic             tick;
  logic             pwm_end;
  logic             apply;

  // The prescaler restarts on a divider load and whenever the ramp is not running.
  assign pre_clr = bus.wren_i | ~bus.en_i | (state_reg == IDLE);

  led_prescaler u_prescaler (
    .clk100 (clk100),
    .rst    (rst),
    .clr    (pre_clr),
    .div    (div_reg),
    .tick   (tick)
  );

  assign pwm_end = (pwm_cnt_reg == DUTY_MAX);
  assign apply   = pwm_end & step_pend_reg;

  always_comb begin
    state_next     = state_reg;
    duty_next      = duty_reg;
    pwm_cnt_next   = pwm_cnt_reg + 1'b1;
    step_pend_next = step_pend_reg;
    led_next       = bus.en_i & (pwm_cnt_reg < duty_reg);

    if (tick) begin
      step_pend_next = 1'b1;
    end else if (apply) begin
      step_pend_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        pwm_cnt_next   = '0;
        duty_next      = '0;
        step_pend_next = 1'b0;
        if (bus.en_i) state_next = RISE;
      end
      RISE: begin
        if (apply) begin
          duty_next = duty_reg + 1'b1;
          if (duty_reg == DUTY_MAX - PWM_W'(1)) state_next = FALL;
        end
      end
      FALL: begin
        if (apply) begin
          duty_next = duty_reg - 1'b1;
          if (duty_reg == PWM_W'(1)) state_next = RISE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (bus.wren_i) step_pend_next = 1'b0;

    if (!bus.en_i) begin
      state_next     = IDLE;
      duty_next      = '0;
      pwm_cnt_next   = '0;
      step_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_reg     <= IDLE;
      div_reg       <= DIV_RST;
      pwm_cnt_reg   <= '0;
      duty_reg      <= '0;
      step_pend_reg <= 1'b0;
      led_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pwm_cnt_reg   <= pwm_cnt_next;
      duty_reg      <= duty_next;
      step_pend_reg <= step_pend_next;
      led_reg       <= led_next;
      if (bus.wren_i) div_reg <= bus.div_i;
    end
  end

  assign bus.led_o   = led_reg;
  assign bus.duty_o  = duty_reg;
  assign bus.phase_o = (state_reg == FALL);

endmodule

// File: doc/led_breathe.md
# led_breathe

PWM "breathing" LED driver that consumes the 5-bit divider value produced by the AXI-Lite register block and drives one board LED (the BLUE RADIO_LED) directly. It ramps LED duty cycle linearly up and down at a rate set by the divider, with glitch-free duty updates on PWM period boundaries. It sits in the `top_io` fabric alongside `led_cnt` and is a drop-in alternative consumer of `led_div*_o`.

## Interface
- `PWM_W`, 8, width of the PWM counter and duty register; the PWM period is 2^PWM_W cycles.
- `DIV_RST`, 5'd16, reset value of the internal divider register.

Ports:
- `clk100`  in  1  single clock for all logic.
- `rst`  in  1  reset; synchronous, active-high.
- `div_i`  in  5  ramp-rate exponent; one duty step is requested every 2^div cycles.
- `wren_i`  in  1  loads `div_i` into the divider register.
- `en_i`  in  1  breathing enable; 0 forces IDLE.
- `led_o`  out  1  registered PWM output.
- `duty_o`  out  PWM_W  current duty value.
- `phase_o`  out  1  0 = rising or idle, 1 = falling.

## Operation
- Divider register `div_q`: loaded from `div_i` when `wren_i`=1. Reset value is `DIV_RST`.
- Prescaler: 32-bit counter `pre_cnt`.
  - Raises `tick` when `pre_cnt` == 2^div_q − 1, then wraps to 0.
  - With `div_q`=0, `tick` is asserted every cycle.
- PWM counter `pwm_cnt` (PWM_W bits): free-running, wraps from 2^PWM_W−1 to 0. `pwm_end` = (`pwm_cnt` == all-ones).
- Step pending flag `step_pend`:
  - Set by `tick`.
  - Cleared when the step is applied at `pwm_end`.
  - Saturates: at most one step is applied per PWM period.
- FSM states: IDLE, RISE, FALL.
  - IDLE: `duty`=0 and `pwm_cnt`, `pre_cnt`, `step_pend` are held at 0. When `en_i`=1, go to RISE.
  - RISE: on `pwm_end` with `step_pend`, `duty`+1. When `duty` reaches 2^PWM_W−1, go to FALL on that same edge.
  - FALL: on `pwm_end` with `step_pend`, `duty`−1. When `duty` reaches 0, go to RISE on that same edge.
  - From any state, `en_i`=0 returns the FSM to IDLE on the next edge and clears `duty` and all counters.
- Duty arithmetic is unsigned PWM_W bits and never wraps; the endpoints turn the ramp around instead.
- `led_o` next = `en_i` & (`pwm_cnt` < `duty`). Therefore `duty`=0 gives an output that is always off, and `duty`=max gives on for 255 of 256 cycles.
- `wren_i` precedence: `wren_i` clears `pre_cnt` and `step_pend` on the same edge, and any `tick` in that cycle is discarded. The next `tick` uses the new `div_q`, occurring 2^div_new cycles after the load.
- `phase_o` = (state == FALL).
- Reset values: `led_o`=0, `duty_o`=0, `phase_o`=0, state IDLE, `div_q`=`DIV_RST`, all counters 0.

## Timing
- `led_o` has 1-cycle latency from `pwm_cnt` and `duty`. The first possible high cycle is one cycle after `pwm_cnt`=0.
- A duty change takes effect only on the edge where `pwm_end`=1, so the new duty governs the next full period.
- Step interval = max(2^div_q, 2^PWM_W) cycles, aligned to a PWM boundary.
- `wren_i` to `div_q` update: 1 cycle.
- `en_i` falling: `led_o`=0 and `duty_o`=0 after exactly 1 edge.
- `en_i` rising: RISE after 1 edge, and `pwm_cnt` starts from 0.
- `rst` mid-ramp: all state and outputs return to reset values on the next edge, overriding `en_i` and `wren_i`.

## Structure
- Package `led_pkg` contains:
  - state typedef `breathe_state_t` {IDLE, RISE, FALL};
  - constant `DIV_W`=5;
  - default `PWM_W` and `DIV_RST`.
  `led_cnt` may import the same package.
- Sub-module `led_prescaler` (ports `clk100`, `rst`, `clr`, `div`, `tick`) holds `pre_cnt` and the terminal-count compare. The FSM, PWM counter and output register stay in the top module.

## Test plan
- Reset, then hold `en_i`=0 for 1000 cycles → `led_o`=0, `duty_o`=0, `phase_o`=0 throughout.
- Load `div_i`=0, then set `en_i`=1:
  - `duty_o` increments by 1 at each 256-cycle boundary and reaches 255 after 255 periods;
  - `phase_o`→1 on that edge;
  - `duty_o` returns to 0 after 255 more periods, and `phase_o`→0.
- Hold at `duty_o`=64 → exactly 64 high cycles of `led_o` per 256-cycle period, first high cycle one clock after `pwm_cnt`=0.
- `div_i`=10 → `duty_o` steps once every 1024 cycles (every 4th PWM period), each step on a `pwm_end` edge.
- Assert `wren_i` in the same cycle as a `tick` → no duty step results from that tick; the next tick arrives exactly 2^div_i cycles later.
- Deassert `en_i` mid-FALL at `duty_o`=100 → next edge `duty_o`=0, `led_o`=0, `phase_o`=0. Re-enable → RISE from 0.
